// File: rtl/soc_timer_ctrl_master_if.sv
// rtl/soc_timer_ctrl_master_if.sv - Avalon-MM link between the timer controller and the timer s1 slave
//
// Purpose: bundles the timer register bus and the timer interrupt line.
// Signals:
//   avm_address    3  timer word address
//   avm_chipselect 1  bus access strobe
//   avm_write_n    1  0 = write, 1 = read while chipselect is high
//   avm_writedata  16 write data
//   avm_readdata   16 read data, valid one cycle after a read cycle
//   irq_in         1  timer interrupt, level
// Modports: master (controller side), slave (timer side).
interface soc_timer_ctrl_master_if;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        irq_in;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write_n,
    output avm_writedata,
    input  avm_readdata,
    input  irq_in
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write_n,
    input  avm_writedata,
    output avm_readdata,
    output irq_in
  );
endinterface

// File: rtl/soc_timer_ctrl_master.sv
// rtl/soc_timer_ctrl_master.sv - Avalon-MM initiator that programs and services the SoC interval timer
//
// Purpose: turns START/STOP/SNAPSHOT commands into timer register access
// sequences and autonomously clears timer timeouts, counting them.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   cmd_valid/ready    command handshake (accepted when both high at an edge)
//   cmd_op             0 START, 1 STOP, 2 SNAPSHOT, 3 reserved
//   cmd_period         period value for START
//   cmd_continuous     continuous-mode bit for START
//   cmd_done           pulse on the last bus cycle of a command
//   snap_valid         pulse when snap_value has been fully updated
//   snap_value         last captured counter snapshot
//   event_count        serviced timeouts, wraps modulo 2^CNT_W
//   avm                timer bus and interrupt (master modport)
module soc_timer_ctrl_master #(
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [31:0]                  cmd_period,
  input  logic                         cmd_continuous,
  output logic                         cmd_done,
  output logic                         snap_valid,
  output logic [31:0]                  snap_value,
  output logic [CNT_W-1:0]             event_count,
  soc_timer_ctrl_master_if.master      avm
);

  typedef enum logic [3:0] {
    S_IDLE, S_PL, S_PH, S_GAP, S_CTL, S_STP,
    S_SNW, S_SNL, S_SNH, S_SNC, S_ICLR, S_IWAIT
  } state_t;

  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_CTRL   = 3'd1;
  localparam logic [2:0] A_PERL   = 3'd2;
  localparam logic [2:0] A_PERH   = 3'd3;
  localparam logic [2:0] A_SNAPL  = 3'd4;
  localparam logic [2:0] A_SNAPH  = 3'd5;

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_period;
  logic               r_cont;
  logic               r_rsv_done;
  logic               r_snap_valid;
  logic [31:0]        r_snap_value;
  logic [CNT_W-1:0]   r_event_count;

  logic               w_accept;
  logic               w_cs;
  logic               w_write_n;
  logic [2:0]         w_addr;
  logic [15:0]        w_wdata;
  logic               w_done;

  // irq_in takes priority: a pending timeout blocks command acceptance.
  assign cmd_ready = (r_state == S_IDLE) && !avm.irq_in;
  assign w_accept  = cmd_ready && cmd_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Bus outputs decode from state and latched fields only.
  always_comb begin
    w_next    = r_state;
    w_cs      = 1'b0;
    w_write_n = 1'b1;
    w_addr    = 3'd0;
    w_wdata   = 16'h0000;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (avm.irq_in) begin
          w_next = S_ICLR;
        end else if (cmd_valid) begin
          case (cmd_op)
            2'd0:    w_next = S_PL;
            2'd1:    w_next = S_STP;
            2'd2:    w_next = S_SNW;
            default: w_next = S_IDLE;
          endcase
        end
      end
      S_PL: begin
        w_cs = 1'b1; w_write_n = 1'b0; w_addr = A_PERL; w_wdata = r_period[15:0];
        w_next = S_PH;
      end
      S_PH: begin
        w_cs = 1'b1; w_write_n = 1'b0; w_addr = A_PERH; w_wdata = r_period[31:16];
        w_next = S_GAP;
      end
      // Idle bus cycle lets the timer's period-write reload settle before start.
      S_GAP: w_next = S_CTL;
      S_CTL: begin
        // control bits {stop,start,cont,ito}
        w_cs = 1'b1; w_write_n = 1'b0; w_addr = A_CTRL;
        w_wdata = {12'h000, 1'b0, 1'b1, r_cont, 1'b1};
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      S_STP: begin
        w_cs = 1'b1; w_write_n = 1'b0; w_addr = A_CTRL; w_wdata = 16'h0009;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      S_SNW: begin
        w_cs = 1'b1; w_write_n = 1'b0; w_addr = A_SNAPL;
        w_next = S_SNL;
      end
      S_SNL: begin
        w_cs = 1'b1; w_addr = A_SNAPL;
        w_next = S_SNH;
      end
      S_SNH: begin
        w_cs = 1'b1; w_addr = A_SNAPH;
        w_next = S_SNC;
      end
      S_SNC: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      S_ICLR: begin
        w_cs = 1'b1; w_write_n = 1'b0; w_addr = A_STATUS;
        w_next = S_IWAIT;
      end
      // The timer's irq is registered; give it a cycle to drop after the clear.
      S_IWAIT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period      <= 32'h0;
      r_cont        <= 1'b0;
      r_rsv_done    <= 1'b0;
      r_snap_valid  <= 1'b0;
      r_snap_value  <= 32'h0;
      r_event_count <= '0;
    end else begin
      if (w_accept) begin
        r_period <= cmd_period;
        r_cont   <= cmd_continuous;
      end
      // A reserved op does no bus work but still completes one cycle later.
      r_rsv_done <= w_accept && (cmd_op == 2'd3);
      // readdata lags the read cycle by one: SNH carries snap_l, SNC snap_h.
      if (r_state == S_SNH) r_snap_value[15:0]  <= avm.avm_readdata;
      if (r_state == S_SNC) r_snap_value[31:16] <= avm.avm_readdata;
      r_snap_valid <= (r_state == S_SNC);
      if (r_state == S_ICLR) r_event_count <= r_event_count + 1'b1;
    end
  end

  assign avm.avm_chipselect = w_cs;
  assign avm.avm_write_n    = w_write_n;
  assign avm.avm_address    = w_addr;
  assign avm.avm_writedata  = w_wdata;
  assign cmd_done           = w_done || r_rsv_done;
  assign snap_valid         = r_snap_valid;
  assign snap_value         = r_snap_value;
  assign event_count        = r_event_count;

endmodule

// File: tb/tb_soc_timer_ctrl_master.sv
// tb/tb_soc_timer_ctrl_master.sv - directed self-checking bench for soc_timer_ctrl_master
module tb_soc_timer_ctrl_master;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [31:0]      cmd_period;
  logic             cmd_continuous;
  logic             cmd_done;
  logic             snap_valid;
  logic [31:0]      snap_value;
  logic [CNT_W-1:0] event_count;

  int total = 0;
  int bad   = 0;

  soc_timer_ctrl_master_if bus_if ();

  soc_timer_ctrl_master #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_period     (cmd_period),
    .cmd_continuous (cmd_continuous),
    .cmd_done       (cmd_done),
    .snap_valid     (snap_valid),
    .snap_value     (snap_value),
    .event_count    (event_count),
    .avm            (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timer read side: snap_l reads 0x1234, snap_h reads 0xABCD, one cycle late.
  always_ff @(posedge clk) begin
    if (bus_if.avm_chipselect && bus_if.avm_write_n) begin
      case (bus_if.avm_address)
        3'd4:    bus_if.avm_readdata <= 16'h1234;
        3'd5:    bus_if.avm_readdata <= 16'hABCD;
        default: bus_if.avm_readdata <= 16'h0000;
      endcase
    end else begin
      bus_if.avm_readdata <= 16'h0000;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic cs, input logic wn,
                         input logic [2:0] a, input logic [15:0] d);
    chk({tag, ".cs"}, {31'b0, bus_if.avm_chipselect}, {31'b0, cs});
    if (cs) begin
      chk({tag, ".wn"}, {31'b0, bus_if.avm_write_n}, {31'b0, wn});
      chk({tag, ".addr"}, {29'b0, bus_if.avm_address}, {29'b0, a});
      if (!wn) chk({tag, ".wdata"}, {16'b0, bus_if.avm_writedata}, {16'b0, d});
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int exp_cnt;
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_period = 32'h0;
    cmd_continuous = 1'b0;
    bus_if.irq_in = 1'b0;
    step();
    step();

    // Reset values
    chk_bus("rst", 1'b0, 1'b1, 3'd0, 16'h0);
    chk("rst.wn", {31'b0, bus_if.avm_write_n}, 32'd1);
    chk("rst.addr", {29'b0, bus_if.avm_address}, 32'd0);
    chk("rst.wdata", {16'b0, bus_if.avm_writedata}, 32'd0);
    chk("rst.done", {31'b0, cmd_done}, 32'd0);
    chk("rst.snapv", {31'b0, snap_valid}, 32'd0);
    chk("rst.snap", snap_value, 32'd0);
    chk("rst.cnt", {28'b0, event_count}, 32'd0);
    chk("rst.ready", {31'b0, cmd_ready}, 32'd1);
    bus_if.irq_in = 1'b1;
    #1;
    chk("rst.ready_irq", {31'b0, cmd_ready}, 32'd0);
    bus_if.irq_in = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    // START period 0x186A0 continuous
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_period = 32'h0001_86A0; cmd_continuous = 1'b1;
    chk("start.ready", {31'b0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0; cmd_period = 32'hFFFF_FFFF; cmd_continuous = 1'b0;
    chk_bus("start.pl", 1'b1, 1'b0, 3'd2, 16'h86A0);
    chk("start.pl_done", {31'b0, cmd_done}, 32'd0);
    step();
    chk_bus("start.ph", 1'b1, 1'b0, 3'd3, 16'h0001);
    step();
    chk_bus("start.gap", 1'b0, 1'b1, 3'd0, 16'h0);
    step();
    chk_bus("start.ctl", 1'b1, 1'b0, 3'd1, 16'h0007);
    chk("start.done", {31'b0, cmd_done}, 32'd1);
    chk("start.ready_busy", {31'b0, cmd_ready}, 32'd0);
    step();
    chk("start.ready_back", {31'b0, cmd_ready}, 32'd1);
    chk("start.done_off", {31'b0, cmd_done}, 32'd0);
    chk_bus("start.idle", 1'b0, 1'b1, 3'd0, 16'h0);

    // STOP
    cmd_valid = 1'b1; cmd_op = 2'd1;
    step();
    cmd_valid = 1'b0;
    chk_bus("stop.stp", 1'b1, 1'b0, 3'd1, 16'h0009);
    chk("stop.done", {31'b0, cmd_done}, 32'd1);
    step();
    chk("stop.ready", {31'b0, cmd_ready}, 32'd1);
    chk("stop.done_off", {31'b0, cmd_done}, 32'd0);

    // SNAPSHOT
    cmd_valid = 1'b1; cmd_op = 2'd2;
    step();
    cmd_valid = 1'b0;
    chk_bus("snap.snw", 1'b1, 1'b0, 3'd4, 16'h0000);
    step();
    chk_bus("snap.snl", 1'b1, 1'b1, 3'd4, 16'h0);
    step();
    chk_bus("snap.snh", 1'b1, 1'b1, 3'd5, 16'h0);
    step();
    chk_bus("snap.snc", 1'b0, 1'b1, 3'd0, 16'h0);
    chk("snap.done", {31'b0, cmd_done}, 32'd1);
    chk("snap.valid_early", {31'b0, snap_valid}, 32'd0);
    step();
    chk("snap.valid", {31'b0, snap_valid}, 32'd1);
    chk("snap.value", snap_value, 32'hABCD_1234);
    chk("snap.ready", {31'b0, cmd_ready}, 32'd1);
    step();
    chk("snap.valid_off", {31'b0, snap_valid}, 32'd0);

    // irq in IDLE with simultaneous STOP request
    bus_if.irq_in = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'd1;
    #1;
    chk("irq.ready_low", {31'b0, cmd_ready}, 32'd0);
    step();
    chk_bus("irq.iclr", 1'b1, 1'b0, 3'd0, 16'h0000);
    chk("irq.cnt_pre", {28'b0, event_count}, 32'd0);
    bus_if.irq_in = 1'b0;
    step();
    chk_bus("irq.iwait", 1'b0, 1'b1, 3'd0, 16'h0);
    chk("irq.cnt", {28'b0, event_count}, 32'd1);
    chk("irq.iwait_ready", {31'b0, cmd_ready}, 32'd0);
    step();
    chk("irq.ready_back", {31'b0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    chk_bus("irq.held_stop", 1'b1, 1'b0, 3'd1, 16'h0009);
    chk("irq.held_done", {31'b0, cmd_done}, 32'd1);
    step();

    // irq during START
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_period = 32'h0000_0010; cmd_continuous = 1'b0;
    step();
    cmd_valid = 1'b0;
    bus_if.irq_in = 1'b1;
    chk_bus("sirq.pl", 1'b1, 1'b0, 3'd2, 16'h0010);
    step();
    chk_bus("sirq.ph", 1'b1, 1'b0, 3'd3, 16'h0000);
    step();
    chk_bus("sirq.gap", 1'b0, 1'b1, 3'd0, 16'h0);
    step();
    chk_bus("sirq.ctl", 1'b1, 1'b0, 3'd1, 16'h0005);
    chk("sirq.done", {31'b0, cmd_done}, 32'd1);
    step();
    chk_bus("sirq.idle", 1'b0, 1'b1, 3'd0, 16'h0);
    chk("sirq.ready", {31'b0, cmd_ready}, 32'd0);
    step();
    chk_bus("sirq.iclr", 1'b1, 1'b0, 3'd0, 16'h0000);
    bus_if.irq_in = 1'b0;
    step();
    chk("sirq.cnt", {28'b0, event_count}, 32'd2);
    step();

    // Reserved op
    cmd_valid = 1'b1; cmd_op = 2'd3;
    step();
    cmd_valid = 1'b0;
    chk("rsv.done", {31'b0, cmd_done}, 32'd1);
    chk_bus("rsv.bus", 1'b0, 1'b1, 3'd0, 16'h0);
    chk("rsv.ready", {31'b0, cmd_ready}, 32'd1);
    step();
    chk("rsv.done_off", {31'b0, cmd_done}, 32'd0);

    // Reset during SNH
    cmd_valid = 1'b1; cmd_op = 2'd2;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk_bus("rsnh.snh", 1'b1, 1'b1, 3'd5, 16'h0);
    reset_n = 1'b0;
    #1;
    chk("rsnh.cs", {31'b0, bus_if.avm_chipselect}, 32'd0);
    chk("rsnh.snap", snap_value, 32'd0);
    chk("rsnh.cnt", {28'b0, event_count}, 32'd0);
    step();
    reset_n = 1'b1;
    chk("rsnh.snapv", {31'b0, snap_valid}, 32'd0);
    step();
    chk("rsnh.snapv2", {31'b0, snap_valid}, 32'd0);
    chk("rsnh.done", {31'b0, cmd_done}, 32'd0);
    chk_bus("rsnh.idle", 1'b0, 1'b1, 3'd0, 16'h0);

    // 15 single timeouts, then one irq held high across two services
    exp_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      bus_if.irq_in = 1'b1;
      step();
      bus_if.irq_in = 1'b0;
      step();
      step();
      exp_cnt = (exp_cnt + 1) % 16;
    end
    chk("wrap.cnt15", {28'b0, event_count}, exp_cnt[31:0]);
    bus_if.irq_in = 1'b1;
    step();
    chk_bus("wrap.iclr1", 1'b1, 1'b0, 3'd0, 16'h0000);
    step();
    step();
    chk("wrap.idle_ready", {31'b0, cmd_ready}, 32'd0);
    step();
    chk_bus("wrap.iclr2", 1'b1, 1'b0, 3'd0, 16'h0000);
    bus_if.irq_in = 1'b0;
    step();
    chk("wrap.cnt17", {28'b0, event_count}, 32'd1);
    step();
    chk("wrap.ready", {31'b0, cmd_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/soc_timer_ctrl_master.md
# soc_timer_ctrl_master

Avalon-MM initiator that programs and services the SoC interval timer's 16-bit register-mapped slave port on behalf of logic that has no bus access. It turns simple start/stop/snapshot commands into the required sequences of timer register accesses. It also services the timer's interrupt autonomously: it clears the timeout status and counts events. It sits between user logic and the timer's s1 slave, on the same clock.

## Interface
- CNT_W, 16, width of the timeout event counter (4..32).
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_op  in  2  command: 0 START, 1 STOP, 2 SNAPSHOT, 3 reserved (accepted, no bus activity).
- cmd_period  in  32  timer period value for START.
- cmd_continuous  in  1  continuous-mode bit for START.
- cmd_done  out  1  one-cycle pulse on the last bus cycle of an accepted command.
- snap_valid  out  1  one-cycle pulse when snap_value updates.
- snap_value  out  32  last captured counter snapshot.
- event_count  out  CNT_W  serviced timeouts, wraps modulo 2^CNT_W.
- avm_address  out  3  timer word address.
- avm_chipselect  out  1  bus access strobe.
- avm_write_n  out  1  0 = write, 1 = read, when chipselect is high.
- avm_writedata  out  16  write data.
- avm_readdata  in  16  read data, valid exactly one cycle after a read cycle.
- irq_in  in  1  timer interrupt, level.

## Operation
- Timer map: 0 status (a write clears timeout), 1 control {stop,start,cont,ito}, 2 period_l, 3 period_h, 4 snap_l (a write captures), 5 snap_h. No waitrequest. Every access takes one cycle.
- States: IDLE, PL, PH, GAP, CTL, STP, SNW, SNL, SNH, SNC, ICLR, IWAIT.
- Command fields are latched on acceptance.
- Bus outputs are a function of the state and the latched registers only. There is no combinational path from cmd_* or irq_in to avm_*.
- cmd_ready = (state == IDLE) && !irq_in.
- IDLE: irq_in high goes to ICLR. irq_in has priority over a simultaneous cmd_valid, and the command is not accepted that cycle. An accepted START goes to PL, STOP to STP, SNAPSHOT to SNW. A reserved op stays in IDLE and pulses cmd_done the next cycle.
- START sequence:
  - PL: write addr 2 = period[15:0].
  - PH: write addr 3 = period[31:16].
  - GAP: chipselect low, so the timer's period-write reload settles.
  - CTL: write addr 1 = {0,1,cont,1} (0x5 or 0x7). cmd_done is high. Then IDLE.
- STOP: STP writes addr 1 = 0x9 (stop, interrupt enable kept). cmd_done is high. Then IDLE.
- SNAPSHOT sequence:
  - SNW: write addr 4, data 0.
  - SNL: read addr 4.
  - SNH: read addr 5; snap_value[15:0] is captured from avm_readdata at the end of this cycle.
  - SNC: chipselect low; snap_value[31:16] is captured. cmd_done is high. Then IDLE.
  - snap_valid pulses in the cycle after SNC.
- IRQ service:
  - ICLR: write addr 0, data 0; event_count increments.
  - IWAIT: one idle cycle so the timer's registered irq deasserts. Then IDLE.
  - If irq_in is still high in IDLE, it is a new timeout and is serviced again.
- irq_in is ignored during any command sequence and is serviced at the next IDLE.

## Timing
- Reset values:
  - state IDLE.
  - avm_chipselect 0, avm_write_n 1, avm_address 0, avm_writedata 0.
  - cmd_done 0, snap_valid 0, snap_value 0, event_count 0.
  - cmd_ready follows ~irq_in.
- Command accepted at edge T0. First bus cycle is T0+1.
- START: bus cycles T+1, T+2, T+4; cmd_done at T+4; cmd_ready returns at T+5.
- STOP: cmd_done at T+1; ready at T+2.
- SNAPSHOT: cmd_done at T+4; snap_valid at T+5 together with cmd_ready.
- IRQ: the status write occurs the cycle after IDLE sees irq_in. event_count updates at the end of the ICLR cycle. Ready returns two cycles after ICLR begins if irq_in is low.
- Reset mid-sequence: all outputs take reset values immediately. A partial sequence is abandoned and not resumed.

## Test plan
- START, period 0x0001_86A0, continuous 1 -> writes (2,0x86A0), (3,0x0001), idle cycle, (1,0x0007); cmd_done 4 cycles after acceptance; timer counter running.
- STOP after START -> single write (1,0x0009); timer counter stops; subsequent irq_in still serviced.
- SNAPSHOT with timer readdata 0x1234 then 0xABCD -> snap_value 0xABCD_1234; snap_valid pulses 5 cycles after acceptance.
- irq_in rises while idle, cmd_valid also high -> command held off, cmd_ready low; write (0,0x0000); event_count 0 -> 1; command accepted two cycles later.
- irq_in asserted during START sequence -> sequence completes unchanged; ICLR follows immediately in next IDLE.
- CNT_W 4, 17 timeouts -> event_count 1; reset_n low during SNH -> chipselect 0 the same cycle, snap_value 0, no snap_valid.
